// File: rtl/apuf_eval_ctrl.sv
// Evaluation controller for an arbiter-PUF switch chain: launches the chain N_EVAL times per
// challenge, samples the synchronised arbiter output each time and returns a majority vote.
//
// state  | meaning
// IDLE   | waiting for a challenge; req_ready high
// LAUNCH | launch high, chain settling; arbiter sampled on the last cycle
// CLEAR  | launch low, chain discharging before the next evaluation
// DONE   | response presented until resp_ready
module apuf_eval_ctrl #(
    parameter int N_STAGES = 64,
    parameter int N_EVAL   = 15,
    parameter int SETTLE   = 8,
    parameter int RST_WAIT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [N_STAGES-1:0]         req_chal,
    output logic [N_STAGES-1:0]         chal,
    output logic                        launch,
    input  logic                        arb_out,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp,
    output logic [$clog2(N_EVAL+1)-1:0] ones_cnt,
    output logic                        stable
);

    localparam int PH_MAX = (SETTLE > RST_WAIT) ? SETTLE : RST_WAIT;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int CNT_W  = $clog2(N_EVAL + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        CLEAR  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                alive_q;
    logic [N_STAGES-1:0] chal_q, chal_d;
    logic                launch_q, launch_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0]    eval_q, eval_d;
    logic [CNT_W-1:0]    ones_q, ones_d;
    logic                resp_q, resp_d;
    logic                stable_q, stable_d;
    logic                arb_s1_q, arb_s2_q;

    always_comb begin
        state_d  = state_q;
        chal_d   = chal_q;
        phase_d  = phase_q;
        eval_d   = eval_q;
        ones_d   = ones_q;
        resp_d   = resp_q;
        stable_d = stable_q;
        case (state_q)
            IDLE: begin
                if (alive_q && req_valid) begin
                    chal_d   = req_chal;
                    ones_d   = '0;
                    eval_d   = '0;
                    resp_d   = 1'b0;
                    stable_d = 1'b0;
                    phase_d  = PH_W'(SETTLE - 1);
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                if (phase_q == '0) begin
                    if (ones_q != CNT_W'(N_EVAL))
                        ones_d = ones_q + CNT_W'(arb_s2_q);
                    phase_d = PH_W'(RST_WAIT - 1);
                    state_d = CLEAR;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            CLEAR: begin
                if (phase_q == '0) begin
                    if (eval_q == CNT_W'(N_EVAL - 1)) begin
                        resp_d   = (ones_q > CNT_W'(N_EVAL / 2));
                        stable_d = (ones_q == '0) || (ones_q == CNT_W'(N_EVAL));
                        state_d  = DONE;
                    end else begin
                        eval_d  = eval_q + CNT_W'(1);
                        phase_d = PH_W'(SETTLE - 1);
                        state_d = LAUNCH;
                    end
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            DONE: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // launch is registered from the next state so it lines up exactly with LAUNCH cycles
        launch_d = (state_d == LAUNCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            alive_q  <= 1'b0;
            chal_q   <= '0;
            launch_q <= 1'b0;
            phase_q  <= '0;
            eval_q   <= '0;
            ones_q   <= '0;
            resp_q   <= 1'b0;
            stable_q <= 1'b0;
            arb_s1_q <= 1'b0;
            arb_s2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            alive_q  <= 1'b1;
            chal_q   <= chal_d;
            launch_q <= launch_d;
            phase_q  <= phase_d;
            eval_q   <= eval_d;
            ones_q   <= ones_d;
            resp_q   <= resp_d;
            stable_q <= stable_d;
            arb_s1_q <= arb_out;
            arb_s2_q <= arb_s1_q;
        end
    end

    assign req_ready  = alive_q && (state_q == IDLE);
    assign resp_valid = (state_q == DONE);
    assign chal       = chal_q;
    assign launch     = launch_q;
    assign resp       = resp_q;
    assign ones_cnt   = ones_q;
    assign stable     = stable_q;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed bench for apuf_eval_ctrl: N_EVAL=5 instance for the main sequence plus an
// N_EVAL=4 instance for the even-count tie case, each with a behavioural arbiter.
module tb_apuf_eval_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        rv0, rr0, launch0, arb0, pv0, prdy0, resp0, stable0;
    logic [15:0] rc0, chal0;
    logic [2:0]  ones0;
    logic        rv1, rr1, launch1, arb1, pv1, prdy1, resp1, stable1;
    logic [15:0] rc1, chal1;
    logic [2:0]  ones1;

    apuf_eval_ctrl #(.N_STAGES(16), .N_EVAL(5), .SETTLE(4), .RST_WAIT(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rr0), .req_chal(rc0),
        .chal(chal0), .launch(launch0), .arb_out(arb0), .resp_valid(pv0),
        .resp_ready(prdy0), .resp(resp0), .ones_cnt(ones0), .stable(stable0)
    );

    apuf_eval_ctrl #(.N_STAGES(16), .N_EVAL(4), .SETTLE(4), .RST_WAIT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rr1), .req_chal(rc1),
        .chal(chal1), .launch(launch1), .arb_out(arb1), .resp_valid(pv1),
        .resp_ready(prdy1), .resp(resp1), .ones_cnt(ones1), .stable(stable1)
    );

    // Arbiter model: resolves one cycle after launch rises to the pattern bit of the current
    // evaluation, and returns to 0 when launch falls.
    logic [4:0] pat0 = '0;
    logic [3:0] pat1 = '0;
    logic       l0_d1 = 1'b0;
    logic       l1_d1 = 1'b0;
    int         ev0 = 0;
    int         ev1 = 0;

    always @(posedge clk) begin
        l0_d1 <= launch0;
        l1_d1 <= launch1;
        if (rv0 && rr0) ev0 <= 0;
        else if (l0_d1 && !launch0) ev0 <= ev0 + 1;
        if (rv1 && rr1) ev1 <= 0;
        else if (l1_d1 && !launch1) ev1 <= ev1 + 1;
    end

    assign arb0 = l0_d1 && launch0 && pat0[ev0 % 5];
    assign arb1 = l1_d1 && launch1 && pat1[ev1 % 4];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_eval(input logic [4:0] p, input logic [15:0] ch, input logic er,
                            input int eo, input logic es, input int hold);
        int bad;
        pat0 = p;
        rc0  = ch;
        rv0  = 1'b1;
        chk("accept_ready", 32'(rr0), 32'd1);
        tick();
        rv0 = 1'b0;
        rc0 = ~ch;
        chk("chal_latched", 32'(chal0), 32'(ch));
        chk("busy_not_ready", 32'(rr0), 32'd0);
        bad = 0;
        for (int e = 0; e < 5; e++) begin
            for (int c = 0; c < 4; c++) begin
                if (launch0 !== 1'b1 || pv0 !== 1'b0) bad++;
                tick();
            end
            for (int c = 0; c < 3; c++) begin
                if (launch0 !== 1'b0 || pv0 !== 1'b0) bad++;
                tick();
            end
        end
        chk("launch_waveform", 32'(bad), 32'd0);
        chk("resp_valid_at_36", 32'(pv0), 32'd1);
        chk("resp", 32'(resp0), 32'(er));
        chk("ones_cnt", 32'(ones0), 32'(eo));
        chk("stable", 32'(stable0), 32'(es));
        chk("chal_held", 32'(chal0), 32'(ch));
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            rv0 = 1'b1;
            rc0 = 16'(h * 16'h1111);
            if (pv0 !== 1'b1 || resp0 !== er || ones0 !== 3'(eo) || stable0 !== es ||
                rr0 !== 1'b0 || chal0 !== ch || launch0 !== 1'b0) bad++;
            tick();
        end
        if (hold > 0) chk("done_hold", 32'(bad), 32'd0);
        rv0   = (hold > 0);
        prdy0 = 1'b1;
        tick();
        prdy0 = 1'b0;
        rv0   = 1'b0;
        chk("resp_valid_drop", 32'(pv0), 32'd0);
        chk("ready_after_hs", 32'(rr0), 32'd1);
        chk("no_accept_on_hs", 32'(launch0), 32'd0);
        chk("chal_after_done", 32'(chal0), 32'(ch));
    endtask

    initial begin
        int bad;
        int lh;
        rst_n = 1'b0;
        rv0 = 1'b0; prdy0 = 1'b0; rc0 = '0;
        rv1 = 1'b0; prdy1 = 1'b0; rc1 = '0;
        repeat (3) tick();
        chk("rst_req_ready", 32'(rr0), 32'd0);
        chk("rst_launch", 32'(launch0), 32'd0);
        chk("rst_chal", 32'(chal0), 32'd0);
        chk("rst_resp_valid", 32'(pv0), 32'd0);
        chk("rst_resp", 32'(resp0), 32'd0);
        chk("rst_ones", 32'(ones0), 32'd0);
        chk("rst_stable", 32'(stable0), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(rr0), 32'd1);
        lh = 0;
        repeat (10) begin
            if (launch0 !== 1'b0) lh++;
            tick();
        end
        chk("idle_no_launch", 32'(lh), 32'd0);

        run_eval(5'b11111, 16'hA5C3, 1'b1, 5, 1'b1, 0);
        run_eval(5'b10101, 16'h1234, 1'b1, 3, 1'b0, 20);
        run_eval(5'b10100, 16'h5A5A, 1'b0, 2, 1'b0, 0);

        pat0 = 5'b11111;
        rc0  = 16'h0F0F;
        rv0  = 1'b1;
        tick();
        rv0 = 1'b0;
        repeat (14) tick();
        chk("third_launch_high", 32'(launch0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_launch_drop", 32'(launch0), 32'd0);
        chk("rst_mid_resp_valid", 32'(pv0), 32'd0);
        chk("rst_mid_ones", 32'(ones0), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        bad = 0;
        repeat (40) begin
            if (pv0 !== 1'b0 || launch0 !== 1'b0 || rr0 !== 1'b1) bad++;
            tick();
        end
        chk("post_rst_idle", 32'(bad), 32'd0);
        chk("post_rst_chal", 32'(chal0), 32'd0);
        run_eval(5'b00001, 16'h3C3C, 1'b0, 1, 1'b0, 0);

        pat1 = 4'b0011;
        rc1  = 16'hBEEF;
        rv1  = 1'b1;
        chk("n4_accept_ready", 32'(rr1), 32'd1);
        tick();
        rv1 = 1'b0;
        repeat (27) tick();
        chk("n4_not_yet_valid", 32'(pv1), 32'd0);
        tick();
        chk("n4_valid_at_29", 32'(pv1), 32'd1);
        chk("n4_tie_resp", 32'(resp1), 32'd0);
        chk("n4_ones", 32'(ones1), 32'd2);
        chk("n4_stable", 32'(stable1), 32'd0);
        chk("n4_chal", 32'(chal1), 32'hBEEF);
        prdy1 = 1'b1;
        tick();
        prdy1 = 1'b0;
        chk("n4_valid_drop", 32'(pv1), 32'd0);
        chk("n4_ready_back", 32'(rr1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apuf_eval_ctrl.md
# apuf_eval_ctrl

Parametrised evaluation controller for an arbiter-PUF switch chain. It accepts a challenge over a valid/ready handshake and drives the chain's challenge bits and launch edge (the inT/inB pair tied together). It then samples the arbiter output after a programmable settle time, repeats the evaluation N_EVAL times, and returns a majority-voted response with a stability flag. It generalises the 16-stage, manually stimulated chain to any stage count, with automatic launch/clear sequencing and repeated-measurement voting.

## Interface
Parameters:
- N_STAGES, 64, challenge width; number of switch stages driven.
- N_EVAL, 15, evaluations per challenge (≥1); the count used for the majority vote.
- SETTLE, 8, cycles launch is held high before sampling (≥3).
- RST_WAIT, 8, cycles launch is held low after each sample (≥1).

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, challenge request valid.
- req_ready, output, 1, controller idle and able to accept a request.
- req_chal, input, N_STAGES, challenge; latched on accept.
- chal, output, N_STAGES, registered challenge driven to the switch chain.
- launch, output, 1, registered edge driven to both chain inputs (inT and inB).
- arb_out, input, 1, arbiter flip-flop output; asynchronous to clk.
- resp_valid, output, 1, response available.
- resp_ready, input, 1, response consumed.
- resp, output, 1, majority response.
- ones_cnt, output, $clog2(N_EVAL+1), number of evaluations that sampled 1.
- stable, output, 1, all N_EVAL samples agreed.

## Operation
- FSM states: IDLE, LAUNCH, CLEAR, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_chal into chal, clear ones_cnt and the eval counter, go to LAUNCH.
- LAUNCH:
  - launch=1 for SETTLE cycles.
  - On the final cycle, ones_cnt += arb_sync, then go to CLEAR.
- CLEAR:
  - launch=0 for RST_WAIT cycles.
  - At the end of the phase: if the eval counter equals N_EVAL-1, go to DONE; otherwise increment the eval counter and go to LAUNCH.
- DONE:
  - resp_valid=1, with resp, ones_cnt and stable held constant.
  - On resp_ready, go to IDLE.
- arb_sync: arb_out passed through a 2-flop synchroniser. The arbiter must resolve within SETTLE-2 cycles of the launch rising edge.
- resp = (ones_cnt > N_EVAL/2), using integer division. For even N_EVAL a tie resolves to 0.
- stable = (ones_cnt==0) || (ones_cnt==N_EVAL).
- ones_cnt saturates at N_EVAL (it cannot exceed N_EVAL by construction).
- chal holds its value through all evaluations and after DONE, until the next accept.
- Phase counter width is $clog2(max(SETTLE,RST_WAIT)+1); eval counter width is $clog2(N_EVAL+1).

## Timing
- Reset values: req_ready=0 while in reset and 1 from the first cycle after reset deassertion. chal=0, launch=0, resp_valid=0, resp=0, ones_cnt=0, stable=0. Synchroniser flops=0. State=IDLE.
- Accept at edge k (IDLE with req_valid):
  - launch is high in cycles k+1 .. k+SETTLE.
  - launch is low in cycles k+SETTLE+1 .. k+SETTLE+RST_WAIT.
  - The pattern repeats N_EVAL times.
- resp_valid rises at cycle k+1+N_EVAL*(SETTLE+RST_WAIT).
- req_ready is 0 from k+1 until the cycle after the resp handshake.
- No request is accepted in the same cycle as the response handshake.
- Response outputs are stable while resp_valid=1 and resp_ready=0, indefinitely. resp_valid deasserts the cycle after the handshake.
- resp_ready asserted outside DONE is ignored.
- req_valid asserted outside IDLE is ignored; req_chal changes there do not affect chal.
- Reset mid-evaluation: launch drops to 0 asynchronously, all outputs return to reset values, no response is produced, state=IDLE.
- N_EVAL=1: a single evaluation. resp equals the sample, and stable is always 1.

## Test plan
Default bench parameters: N_STAGES=16, N_EVAL=5, SETTLE=4, RST_WAIT=3, with a behavioural arbiter model that drives arb_out 1 cycle after the launch rise.

- Reset then idle → all outputs 0, req_ready=1 on the first cycle after rst_n rises, launch never toggles.
- Accept req_chal=16'hA5C3 with the model always returning 1:
  - chal=16'hA5C3; launch high 4 cycles, low 3 cycles, five times.
  - resp_valid exactly 36 cycles after accept.
  - resp=1, ones_cnt=5, stable=1.
- Model returning 1,0,1,0,1 → resp=1, ones_cnt=3, stable=0. With 0,0,1,0,1 → resp=0, ones_cnt=2, stable=0.
- resp_ready held low 20 cycles in DONE → outputs held constant, req_ready=0, a new req_valid is ignored. Raising resp_ready → resp_valid=0 next cycle and req_ready=1.
- rst_n pulsed low during the third LAUNCH phase → launch=0 immediately, resp_valid never asserts. The next request completes normally with ones_cnt counted from 0.
- N_EVAL=4, samples 1,1,0,0 → resp=0 (tie), ones_cnt=2, stable=0, latency 1+4*7=29.
